// File: rtl/cpu_execute_alu.sv
// Execute stage: single-cycle ALU/shift/compare with an iterative radix-2 multiplier.
// It drives a registered one-cycle write-back request and holds a persistent compare-flags register.
module cpu_execute_alu #(
  parameter int WIDTH  = 32,
  parameter int REGIDX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [4:0]        op_i,
  input  logic [WIDTH-1:0]  regA_i,
  input  logic [WIDTH-1:0]  regB_i,
  input  logic [WIDTH-1:0]  operand_i,
  input  logic [REGIDX-1:0] register_write_index_i,
  output logic              stall_o,
  output logic              register_write_enable_o,
  output logic [REGIDX-1:0] register_write_index_o,
  output logic [WIDTH-1:0]  result_o,
  output logic [4:0]        flags_o,
  output logic              illegal_o
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH) + 1;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_MOV  = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_INC  = 5'd5;
  localparam logic [4:0] OP_DEC  = 5'd6;
  localparam logic [4:0] OP_AND  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_XOR  = 5'd9;
  localparam logic [4:0] OP_NOT  = 5'd10;
  localparam logic [4:0] OP_NEG  = 5'd11;
  localparam logic [4:0] OP_LSHR = 5'd12;
  localparam logic [4:0] OP_ASHL = 5'd13;
  localparam logic [4:0] OP_ASHR = 5'd14;
  localparam logic [4:0] OP_CMP  = 5'd15;
  localparam logic [4:0] OP_MUL  = 5'd16;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  mplier_q, mplier_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [REGIDX-1:0] mul_idx_q, mul_idx_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic [REGIDX-1:0] idx_q, idx_d;
  logic              we_q, we_d;
  logic [4:0]        flags_q, flags_d;
  logic              illegal_q, illegal_d;

  function automatic logic [WIDTH-1:0] alu_op(input logic [4:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] imm);
    logic signed [WIDTH-1:0] a_s;
    logic [SHW-1:0]          sh;
    a_s = a;
    sh  = b[SHW-1:0];
    case (op)
      OP_LDI:  alu_op = imm;
      OP_MOV:  alu_op = b;
      OP_ADD:  alu_op = a + b;
      OP_SUB:  alu_op = a - b;
      OP_INC:  alu_op = a + imm;
      OP_DEC:  alu_op = a - imm;
      OP_AND:  alu_op = a & b;
      OP_OR:   alu_op = a | b;
      OP_XOR:  alu_op = a ^ b;
      OP_NOT:  alu_op = ~b;
      OP_NEG:  alu_op = '0 - b;
      OP_LSHR: alu_op = a >> sh;
      OP_ASHL: alu_op = a << sh;
      OP_ASHR: alu_op = a_s >>> sh;
      default: alu_op = '0;
    endcase
  endfunction

  function automatic logic [4:0] cmp_flags(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] a_s;
    logic signed [WIDTH-1:0] b_s;
    a_s = a;
    b_s = b;
    cmp_flags = {a > b, a < b, a_s > b_s, a_s < b_s, a == b};
  endfunction

  function automatic logic [WIDTH-1:0] partial(input logic bit_i,
                                               input logic [WIDTH-1:0] m);
    partial = bit_i ? m : '0;
  endfunction

  assign stall_o                 = (state_q == S_MUL) && (count_q > CNTW'(1));
  assign register_write_enable_o = we_q;
  assign register_write_index_o  = idx_q;
  assign result_o                = result_q;
  assign flags_o                 = flags_q;
  assign illegal_o               = illegal_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    mul_idx_d = mul_idx_q;
    result_d  = result_q;
    idx_d     = idx_q;
    flags_d   = flags_q;
    we_d      = 1'b0;
    illegal_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          case (op_i)
            OP_NOP: ;
            OP_CMP: flags_d = cmp_flags(regA_i, regB_i);
            OP_MUL: begin
              state_d   = S_MUL;
              count_d   = CNTW'(WIDTH);
              mcand_d   = regA_i;
              mplier_d  = regB_i;
              acc_d     = '0;
              mul_idx_d = register_write_index_i;
            end
            OP_LDI, OP_MOV, OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_AND, OP_OR,
            OP_XOR, OP_NOT, OP_NEG, OP_LSHR, OP_ASHL, OP_ASHR: begin
              result_d = alu_op(op_i, regA_i, regB_i, operand_i);
              idx_d    = register_write_index_i;
              we_d     = 1'b1;
            end
            default: illegal_d = 1'b1;
          endcase
        end
      end
      S_MUL: begin
        count_d = count_q - CNTW'(1);
        if (count_q > CNTW'(2)) begin
          acc_d    = acc_q + partial(mplier_q[0], mcand_q);
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
        end else begin
          // Last cycle retires the two remaining multiplier bits, so the result is registered by the cycle stall drops.
          result_d = acc_q + partial(mplier_q[0], mcand_q)
                           + partial(mplier_q[1], mcand_q << 1);
          idx_d    = mul_idx_q;
          we_d     = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      flags_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      flags_q   <= flags_d;
      illegal_q <= illegal_d;
    end
  end

  // Multiplier operands are only meaningful in S_MUL, so they carry no reset.
  always_ff @(posedge clk_i) begin
    mcand_q   <= mcand_d;
    mplier_q  <= mplier_d;
    acc_q     <= acc_d;
    mul_idx_q <= mul_idx_d;
  end

endmodule

// File: tb/tb_cpu_execute_alu.sv
// Scoreboard bench for cpu_execute_alu: the driver pushes expected write-backs, illegal pulses and flags.
// A negedge monitor pops the expectations and compares them with the DUT outputs.
module tb_cpu_execute_alu;
  localparam int W = 32;
  localparam int MAXC = 20000;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [4:0]  op;
  logic [31:0] a, b, imm;
  logic [3:0]  widx;
  logic        stall_o, we_o, illegal_o;
  logic [3:0]  idx_o;
  logic [31:0] result_o;
  logic [4:0]  flags_o;

  always #5 clk = ~clk;

  cpu_execute_alu #(.WIDTH(W), .REGIDX(4)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .op_i(op),
    .regA_i(a), .regB_i(b), .operand_i(imm),
    .register_write_index_i(widx),
    .stall_o(stall_o),
    .register_write_enable_o(we_o),
    .register_write_index_o(idx_o),
    .result_o(result_o),
    .flags_o(flags_o),
    .illegal_o(illegal_o)
  );

  typedef struct { int cyc; logic [3:0] idx; logic [31:0] data; } wr_t;
  typedef struct { int cyc; logic [31:0] res; } ill_t;
  typedef struct { int cyc; logic [4:0] flags; } fl_t;

  wr_t  wq[$];
  ill_t iq[$];
  fl_t  fq[$];
  bit   exp_stall [0:MAXC];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   mon_on = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  cur_flags = '0;
  wr_t  mon_w;
  ill_t mon_i;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_op(input int o, input logic [31:0] x,
                                         input logic [31:0] y, input logic [31:0] k);
    int unsigned s;
    logic [63:0] p;
    s = y % 32;
    case (o)
      1:  return k;
      2:  return y;
      3:  return x + y;
      4:  return x - y;
      5:  return x + k;
      6:  return x - k;
      7:  return x & y;
      8:  return x | y;
      9:  return x ^ y;
      10: return ~y;
      11: return 32'd0 - y;
      12: return x >> s;
      13: return x << s;
      14: return 32'($signed(x) >>> s);
      16: begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [4:0] ref_flags(input logic [31:0] x, input logic [31:0] y);
    return {x > y, x < y, $signed(x) > $signed(y), $signed(x) < $signed(y), x == y};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, expv);
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (mon_on) begin
      if (we_o) begin
        if (wq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL wb_unexpected cyc=%0d got idx=%0d data=%h expected no write", cyc, idx_o, result_o);
        end else begin
          mon_w = wq.pop_front();
          check("wb_cycle", cyc, mon_w.cyc);
          check("wb_idx", idx_o, mon_w.idx);
          check("wb_data", result_o, mon_w.data);
        end
      end
      while (wq.size() > 0 && wq[0].cyc < cyc) begin
        mon_w = wq.pop_front();
        tests++;
        fails++;
        $display("FAIL wb_missing cyc=%0d got no write expected idx=%0d data=%h at cyc %0d",
                 cyc, mon_w.idx, mon_w.data, mon_w.cyc);
      end
      if (illegal_o) begin
        if (iq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL illegal_unexpected cyc=%0d got pulse expected none", cyc);
        end else begin
          mon_i = iq.pop_front();
          check("illegal_cycle", cyc, mon_i.cyc);
          check("illegal_result_held", result_o, mon_i.res);
          check("illegal_we", we_o, 1'b0);
        end
      end
      while (iq.size() > 0 && iq[0].cyc < cyc) begin
        mon_i = iq.pop_front();
        tests++;
        fails++;
        $display("FAIL illegal_missing cyc=%0d got no pulse expected at cyc %0d", cyc, mon_i.cyc);
      end
      while (fq.size() > 0 && fq[0].cyc <= cyc) cur_flags = fq.pop_front().flags;
      check("flags", flags_o, cur_flags);
      check("stall", stall_o, exp_stall[cyc]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) step();
  endtask

  // Present an operation, hold it through any stall, and record the expected response at acceptance.
  task automatic issue(input logic [4:0] o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] iimm, input logic [3:0] ix,
                       input bit use_exp = 0, input logic [31:0] xexp = '0);
    int guard;
    int c;
    logic [31:0] r;
    wr_t w;
    ill_t il;
    fl_t f;
    valid = 1'b1; op = o; a = ia; b = ib; imm = iimm; widx = ix;
    guard = 0;
    while (exp_stall[cyc] && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout cyc=%0d got stall after 100 cycles expected release", cyc);
    end
    c = cyc;
    r = use_exp ? xexp : ref_op(int'(o), ia, ib, iimm);
    if (o == 5'd15) begin
      f.cyc = c + 1;
      f.flags = use_exp ? xexp[4:0] : ref_flags(ia, ib);
      fq.push_back(f);
    end else if (o == 5'd16) begin
      for (int k = 1; k < W; k++) if (c + k <= MAXC) exp_stall[c + k] = 1'b1;
      w.cyc = c + W; w.idx = ix; w.data = r;
      wq.push_back(w);
      last_res = r;
    end else if (o >= 5'd1 && o <= 5'd14) begin
      w.cyc = c + 1; w.idx = ix; w.data = r;
      wq.push_back(w);
      last_res = r;
    end else if (o >= 5'd17) begin
      il.cyc = c + 1; il.res = last_res;
      iq.push_back(il);
    end
    step();
    valid = 1'b0;
  endtask

  task automatic do_reset();
    int c;
    fl_t f;
    c = cyc;
    rst = 1'b1;
    valid = 1'b0;
    for (int i = wq.size() - 1; i >= 0; i--) if (wq[i].cyc > c) wq.delete(i);
    for (int i = iq.size() - 1; i >= 0; i--) if (iq[i].cyc > c) iq.delete(i);
    for (int i = fq.size() - 1; i >= 0; i--) if (fq[i].cyc > c) fq.delete(i);
    f.cyc = c + 1; f.flags = '0;
    fq.push_back(f);
    for (int k = 1; k <= 40; k++) if (c + k <= MAXC) exp_stall[c + k] = 1'b0;
    last_res = '0;
    step();
    check("rst_result", result_o, 32'h0);
    check("rst_idx", idx_o, 4'h0);
    check("rst_we", we_o, 1'b0);
    check("rst_stall", stall_o, 1'b0);
    check("rst_flags", flags_o, 5'h0);
    check("rst_illegal", illegal_o, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d got no finish expected completion", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] ro;
    int r;
    rst = 1'b1; valid = 1'b0; op = '0; a = '0; b = '0; imm = '0; widx = '0;
    repeat (3) step();
    check("init_result", result_o, 32'h0);
    check("init_idx", idx_o, 4'h0);
    check("init_we", we_o, 1'b0);
    check("init_stall", stall_o, 1'b0);
    check("init_flags", flags_o, 5'h0);
    check("init_illegal", illegal_o, 1'b0);
    rst = 1'b0;
    mon_on = 1'b1;

    issue(5'd1, 32'h0, 32'h0, 32'h1234_5678, 4'd3, 1, 32'h1234_5678);
    issue(5'd0, 32'h0, 32'h0, 32'h0, 4'd0);
    issue(5'd6, 32'h0, 32'h0, 32'h1, 4'd5, 1, 32'hFFFF_FFFF);
    issue(5'd3, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'd6, 1, 32'h0);
    issue(5'd14, 32'h8000_0000, 32'h24, 32'h0, 4'd7, 1, 32'hF800_0000);
    issue(5'd15, 32'hFFFF_FFFF, 32'h1, 32'h0, 4'd0, 1, 32'h12);
    issue(5'd3, 32'h3, 32'h4, 32'h0, 4'd1, 1, 32'h7);
    idle(2);
    issue(5'd16, 32'h0001_0001, 32'h0001_0001, 32'h0, 4'd9, 1, 32'h0002_0001);
    issue(5'd1, 32'h0, 32'h0, 32'hCAFE_0001, 4'd10, 1, 32'hCAFE_0001);
    idle(3);
    issue(5'd16, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0, 4'd11);
    idle(9);
    do_reset();
    issue(5'd1, 32'h0, 32'h0, 32'h0000_A5A5, 4'd2, 1, 32'h0000_A5A5);
    idle(40);
    issue(5'd15, 32'h5, 32'h5, 32'h0, 4'd0, 1, 32'h01);
    issue(5'd20, 32'h1, 32'h2, 32'h3, 4'd4);
    idle(2);

    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       ro = 5'd0;
      else if (r < 10) ro = 5'($urandom_range(17, 31));
      else if (r < 18) ro = 5'd16;
      else if (r < 28) ro = 5'd15;
      else             ro = 5'($urandom_range(1, 14));
      issue(ro, rnd_val(), rnd_val(), rnd_val(), 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    idle(40);
    check("wq_drained", wq.size(), 32'd0);
    check("iq_drained", iq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
